// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and a word-addressed instruction memory
// and produces one {instruction, PC, valid} triple per cycle for the IF/ID buffer.
module if_fetch_stage #(
    parameter int          DEPTH      = 64,
    parameter int          ADDR_W     = 6,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [31:0]       redirect_pc,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_out,
    output logic              valid_out,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic [31:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] fetch_idx;
    logic [31:0]       fetch_word;
    logic              pc_out_of_range;
    logic              unused_redirect_low;

    // Redirect targets are word aligned; the two byte-offset bits are dropped.
    assign unused_redirect_low = ^redirect_pc[1:0];

    assign fetch_idx       = pc_q[ADDR_W+1:2];
    assign fetch_word      = mem_q[fetch_idx];
    assign pc_out_of_range = (pc_q[31:ADDR_W+2] != '0);

    // Loader write port: active in every state, reset included.
    // NOTE: the memory array is deliberately not reset so loaded programs survive
    // a reset and the array maps onto RAM; the combinational read above sees the
    // pre-edge contents, giving read-before-write on a same-cycle collision.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Control and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the values from before the edge regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and next-output selection; RUN decisions follow priority
    // redirect > stall > out-of-range > halt word > normal fetch.
    always_comb begin
        // NOTE: every target gets a hold default first so no path infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        fault_d  = fault_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect_en) begin
                    pc_d    = {redirect_pc[31:2], 2'b00};
                    instr_d = '0;
                    valid_d = 1'b0;
                end else if (stall) begin
                    // hold everything
                end else if (pc_out_of_range) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                    state_d = HALT;
                end else if (fetch_word == HALT_INSTR) begin
                    instr_d  = HALT_INSTR;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    state_d  = HALT;
                end else begin
                    instr_d  = fetch_word;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                end
            end
            HALT: begin
                instr_d = '0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
    assign valid_out = valid_q;
    assign halted    = (state_q == HALT);
    assign fault     = fault_q;

endmodule
